// File: rtl/ram_controller.sv
// ram_controller: write-buffered memory stage with read forwarding in front of a synchronous RAM.
module ram_controller #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int WB_DEPTH = 4,
    parameter int RAM_LAT  = 1
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_wren,
    input  logic [DATA_W-1:0] ram_q
);
    localparam int PW = $clog2(WB_DEPTH);
    localparam int CW = $clog2(WB_DEPTH + 1);
    localparam int LW = $clog2(RAM_LAT + 1);
    typedef enum logic {IDLE, RD_WAIT} state_t;
    state_t state, state_nx;
    logic [ADDR_W-1:0] wb_addr [WB_DEPTH];
    logic [DATA_W-1:0] wb_data [WB_DEPTH];
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count;
    logic [LW-1:0] cnt;
    logic wb_full, accept, rd_acc, wr_acc, hit, drain;
    logic [DATA_W-1:0] hit_data;
    assign wb_full   = count == CW'(WB_DEPTH);
    assign req_ready = state == IDLE && !wb_full && resetn;
    assign accept    = req_valid && req_ready;
    assign rd_acc    = accept && !req_we;
    assign wr_acc    = accept && req_we;
    assign drain     = state == IDLE && count != '0 && !rd_acc;
    // walk oldest to youngest so the last match wins
    always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int i = 0; i < WB_DEPTH; i++)
            if (CW'(i) < count && wb_addr[head + PW'(i)] == req_addr) begin
                hit      = 1'b1;
                hit_data = wb_data[head + PW'(i)];
            end
    end
    always_comb begin
        state_nx = state;
        if (state == IDLE && rd_acc && !hit) state_nx = RD_WAIT;
        if (state == RD_WAIT && cnt == '0) state_nx = IDLE;
    end
    always_ff @(posedge clock)
        if (wr_acc) begin
            wb_addr[tail] <= req_addr;
            wb_data[tail] <= req_wdata;
        end
    always_ff @(posedge clock or negedge resetn)
        if (!resetn) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            ram_wren  <= 1'b0;
        end else begin
            state     <= state_nx;
            rsp_valid <= 1'b0;
            ram_wren  <= 1'b0;
            count     <= count + CW'(wr_acc) - CW'(drain);
            if (wr_acc) tail <= tail + 1'b1;
            if (drain) begin
                head      <= head + 1'b1;
                ram_addr  <= wb_addr[head];
                ram_wdata <= wb_data[head];
                ram_wren  <= 1'b1;
            end
            if (rd_acc && hit) begin
                rsp_valid <= 1'b1;
                rsp_data  <= hit_data;
            end
            if (rd_acc && !hit) begin
                ram_addr <= req_addr;
                cnt      <= LW'(RAM_LAT);
            end
            if (state == RD_WAIT) begin
                if (cnt == '0) begin
                    rsp_valid <= 1'b1;
                    rsp_data  <= ram_q;
                end else cnt <= cnt - 1'b1;
            end
        end
endmodule
